// File: rtl/register_bus_master_pkg.sv
// Shared definitions for the register bus: module-enable codes, address and
// data field widths, and the bus master FSM state encoding. Responders on the
// same bus import this package so the address split and codes stay in one place.
package register_bus_master_pkg;

  localparam int MODULE_W  = 4;    // module-enable code field, addressBus[15:12]
  localparam int SUBADDR_W = 12;   // sub-address field, addressBus[11:0]
  localparam int ADDR_W    = MODULE_W + SUBADDR_W;
  localparam int DATA_W    = 256;

  // Module-enable codes
  localparam logic [MODULE_W-1:0] MOD_INSTRUCTION = 4'h0;
  localparam logic [MODULE_W-1:0] MOD_MEMORY      = 4'h1;
  localparam logic [MODULE_W-1:0] MOD_ALU         = 4'h2;
  localparam logic [MODULE_W-1:0] MOD_EXE         = 4'h3;
  localparam logic [MODULE_W-1:0] MOD_REGISTER    = 4'h4;

  // Bus master FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } busState_t;

endpackage

// File: rtl/register_bus_master.sv
// register_bus_master
// Turns one requester command at a time into a register-bus access: a single
// ISSUE cycle with address and one strobe, an optional read wait, then a held
// response until the requester takes it.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. cmdReady is 1 only while idle; rspValid stays 1
// with rspData/rspError stable until the edge on which rspReady is 1.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmdValid/cmdReady   command handshake
//   cmdWrite            1 = write, 0 = read
//   cmdModule           module-enable code; codes above MAX_MODULE are rejected
//   cmdAddr, cmdData    sub-address and write data
//   addressBus          {module, sub-address} to responders
//   writeToReg          write strobe (ISSUE cycle only)
//   readFromReg         read strobe (ISSUE cycle only)
//   inputDataBus        write data to responders (ISSUE cycle of writes only)
//   outputDataBus       responder read data, sampled READ_WAIT cycles after
//                       the strobe edge
//   rspValid/rspReady   response handshake
//   rspData, rspError   read data (0 for writes/errors), rejection flag
//   debugState          current FSM state, for observation only
module register_bus_master
  import register_bus_master_pkg::*;
#(
  parameter int                  READ_WAIT  = 1,     // 1..15
  parameter logic [MODULE_W-1:0] MAX_MODULE = 4'h4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic                 cmdWrite,
  input  logic [MODULE_W-1:0]  cmdModule,
  input  logic [SUBADDR_W-1:0] cmdAddr,
  input  logic [DATA_W-1:0]    cmdData,
  output logic [ADDR_W-1:0]    addressBus,
  output logic                 writeToReg,
  output logic                 readFromReg,
  output logic [DATA_W-1:0]    inputDataBus,
  input  logic [DATA_W-1:0]    outputDataBus,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DATA_W-1:0]    rspData,
  output logic                 rspError,
  output logic [1:0]           debugState
);

  localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT - 1);

  busState_t  state;
  logic [3:0] waitCount;
  logic       capWrite;   // direction of the accepted command

  assign cmdReady   = (state == ST_IDLE);
  assign rspValid   = (state == ST_RESPOND);
  assign debugState = state;

  // The accepted command is captured straight into the address and data
  // output registers; addressBus then holds it through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      waitCount    <= '0;
      capWrite     <= 1'b0;
      addressBus   <= '0;
      writeToReg   <= 1'b0;
      readFromReg  <= 1'b0;
      inputDataBus <= '0;
      rspData      <= '0;
      rspError     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmdValid) begin
            capWrite <= cmdWrite;
            if (cmdModule > MAX_MODULE) begin
              // Rejected: straight to the response, bus left untouched.
              state    <= ST_RESPOND;
              rspError <= 1'b1;
              rspData  <= '0;
            end else begin
              state        <= ST_ISSUE;
              addressBus   <= {cmdModule, cmdAddr};
              writeToReg   <= cmdWrite;
              readFromReg  <= ~cmdWrite;
              inputDataBus <= cmdWrite ? cmdData : '0;
              rspError     <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          writeToReg   <= 1'b0;
          readFromReg  <= 1'b0;
          inputDataBus <= '0;
          if (capWrite) begin
            state   <= ST_RESPOND;
            rspData <= '0;
          end else begin
            state     <= ST_WAIT;
            waitCount <= WAIT_LOAD;
          end
        end

        ST_WAIT: begin
          if (waitCount == 4'd0) begin
            rspData <= outputDataBus;
            state   <= ST_RESPOND;
          end else begin
            waitCount <= waitCount - 4'd1;
          end
        end

        ST_RESPOND: begin
          if (rspReady) begin
            state      <= ST_IDLE;
            addressBus <= '0;
            rspError   <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_bus_master.sv
// Bench for register_bus_master: two instances, READ_WAIT=1 and READ_WAIT=3,
// each with its own responder model. Commands are driven on the falling edge
// and outputs sampled on the falling edge.
module tb_register_bus_master;
  import register_bus_master_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset         [2];
  logic               cmd_valid     [2];
  logic               cmd_ready     [2];
  logic               cmd_write     [2];
  logic [3:0]         cmd_module    [2];
  logic [11:0]        cmd_addr      [2];
  logic [255:0]       cmd_data      [2];
  logic [15:0]        address_bus   [2];
  logic               write_to_reg  [2];
  logic               read_from_reg [2];
  logic [255:0]       input_data_bus[2];
  logic               rsp_valid     [2];
  logic               rsp_ready     [2];
  logic [255:0]       rsp_data      [2];
  logic               rsp_error     [2];
  logic [1:0]         dbg_state     [2];
  logic [255:0]       rd_base       [2];   // responder's first read-data word

  int check_cnt = 0;
  int pass_cnt  = 0;

  function automatic int rw_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [255:0] resp_bus = '0;
    int           age = 0;
    logic         strobe_seen;

    register_bus_master #(.READ_WAIT((g == 0) ? 1 : 3), .MAX_MODULE(4'h4)) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .cmdValid     (cmd_valid[g]),
      .cmdReady     (cmd_ready[g]),
      .cmdWrite     (cmd_write[g]),
      .cmdModule    (cmd_module[g]),
      .cmdAddr      (cmd_addr[g]),
      .cmdData      (cmd_data[g]),
      .addressBus   (address_bus[g]),
      .writeToReg   (write_to_reg[g]),
      .readFromReg  (read_from_reg[g]),
      .inputDataBus (input_data_bus[g]),
      .outputDataBus(resp_bus),
      .rspValid     (rsp_valid[g]),
      .rspReady     (rsp_ready[g]),
      .rspData      (rsp_data[g]),
      .rspError     (rsp_error[g]),
      .debugState   (dbg_state[g])
    );

    // Responder: from the strobe edge it drives rd_base, then rd_base+1,
    // rd_base+2, ... one step per cycle, so the captured word reveals which
    // cycle the master sampled.
    always begin
      @(posedge clk);
      strobe_seen = read_from_reg[g];
      #1;
      if (strobe_seen) age = 0;
      else age = age + 1;
      resp_bus = rd_base[g] + 256'(age);
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle_zero(input int d, input string tag);
    check({tag, "_cmd_ready"}, 256'(cmd_ready[d]), 256'(1));
    check({tag, "_rsp_valid"}, 256'(rsp_valid[d]), 256'(0));
    check({tag, "_addr"}, 256'(address_bus[d]), 256'(0));
    check({tag, "_strobes"}, 256'({write_to_reg[d], read_from_reg[d]}), 256'(0));
    check({tag, "_in_data"}, input_data_bus[d], '0);
    check({tag, "_rsp_data"}, rsp_data[d], '0);
    check({tag, "_rsp_error"}, 256'(rsp_error[d]), 256'(0));
  endtask

  // ---------------------------------------------------------------- driver
  // One full transaction; the reference model is the latency/response rule:
  // error -> 1 cycle, write -> 2, read -> 2+READ_WAIT, read data is the
  // responder word READ_WAIT-1 steps after the strobe edge.
  task automatic run_cmd(input int d, input logic wr, input logic [3:0] md,
                         input logic [11:0] ad, input logic [255:0] dt, input int hold);
    logic         exp_err;
    int           exp_lat;
    int           lat;
    logic [255:0] exp_data;
    logic [255:0] exp_q[$];
    exp_err  = (md > 4'h4);
    exp_lat  = exp_err ? 1 : (wr ? 2 : 2 + rw_of(d));
    exp_q.push_back((exp_err || wr) ? '0 : rd_base[d] + 256'(rw_of(d) - 1));
    check("cmd_ready_idle", 256'(cmd_ready[d]), 256'(1));
    cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_module[d] = md;
    cmd_addr[d] = ad; cmd_data[d] = dt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[d] = 1'b0; cmd_data[d] = '0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      check("wr_strobe", 256'(write_to_reg[d]), 256'(lat == 1 && !exp_err && wr));
      check("rd_strobe", 256'(read_from_reg[d]), 256'(lat == 1 && !exp_err && !wr));
      check("in_data", input_data_bus[d], (lat == 1 && !exp_err && wr) ? dt : '0);
      check("addr", 256'(address_bus[d]), exp_err ? 256'(0) : 256'({md, ad}));
      check("cmd_ready_busy", 256'(cmd_ready[d]), 256'(0));
      @(negedge clk);
      lat++;
    end
    exp_data = exp_q.pop_front();
    check("latency", 256'(lat), 256'(exp_lat));
    check("rsp_error", 256'(rsp_error[d]), 256'(exp_err));
    check("rsp_data", rsp_data[d], exp_data);
    check("rsp_strobes", 256'({write_to_reg[d], read_from_reg[d]}), 256'(0));
    if (exp_err) check("err_addr", 256'(address_bus[d]), 256'(0));
    // Pending command during the hold must not be taken until after rspReady.
    if (hold > 0) begin
      cmd_valid[d] = 1'b1; cmd_write[d] = 1'b1; cmd_module[d] = 4'h1;
      cmd_addr[d] = 12'h0; cmd_data[d] = '0;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 256'(rsp_valid[d]), 256'(1));
      check("hold_data", rsp_data[d], exp_data);
      check("hold_error", 256'(rsp_error[d]), 256'(exp_err));
      check("hold_cmd_ready", 256'(cmd_ready[d]), 256'(0));
      @(negedge clk);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    cmd_valid[d] = 1'b0;
    check("post_rsp_valid", 256'(rsp_valid[d]), 256'(0));
    check("post_cmd_ready", 256'(cmd_ready[d]), 256'(1));
    check("post_addr", 256'(address_bus[d]), 256'(0));
    check("post_rsp_data", rsp_data[d], exp_data);
  endtask

  task automatic reset_in_wait(input int d);
    rd_base[d] = rand256();
    cmd_valid[d] = 1'b1; cmd_write[d] = 1'b0; cmd_module[d] = 4'h2;
    cmd_addr[d] = 12'($urandom); cmd_data[d] = '0;
    @(posedge clk);
    @(negedge clk);                 // ISSUE
    cmd_valid[d] = 1'b0;
    @(negedge clk);                 // first WAIT cycle
    check("wait_rd_strobe", 256'(read_from_reg[d]), 256'(0));
    check("wait_rsp_valid", 256'(rsp_valid[d]), 256'(0));
    reset[d] = 1'b1;
    @(negedge clk);
    reset[d] = 1'b0;
    check_idle_zero(d, "abort");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 256'(rsp_valid[d]), 256'(0));
      check("abort_no_strobe", 256'({write_to_reg[d], read_from_reg[d]}), 256'(0));
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0;
      cmd_module[d] = '0; cmd_addr[d] = '0; cmd_data[d] = '0;
      rsp_ready[d] = 1'b0; rd_base[d] = '0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;
    for (int d = 0; d < 2; d++) check_idle_zero(d, "reset");

    for (int d = 0; d < 2; d++) begin
      // Directed: write to register module
      run_cmd(d, 1'b1, 4'h4, 12'h003, 256'hA5, 0);
      // Directed: read of 16'h4000 with responder word 0x1234
      rd_base[d] = 256'h1234;
      run_cmd(d, 1'b0, 4'h4, 12'h000, '0, 0);
      // Directed: illegal module code
      run_cmd(d, 1'b1, 4'h7, 12'h055, rand256(), 0);
      // Directed: long hold of the response
      rd_base[d] = rand256();
      run_cmd(d, 1'b0, 4'h3, 12'hFFF, '0, 5);
      // Boundary module codes
      run_cmd(d, 1'b0, 4'h5, 12'h001, '0, 1);
      run_cmd(d, 1'b1, 4'hF, 12'h001, rand256(), 0);
      run_cmd(d, 1'b1, 4'h0, 12'h000, rand256(), 0);
    end

    // Randomized traffic
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 20; n++) begin
        rd_base[d] = rand256();
        run_cmd(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)),
                12'($urandom), rand256(), $urandom_range(0, 3));
      end
    end

    // Reset in the middle of a READ_WAIT=3 read, then a normal read.
    reset_in_wait(1);
    rd_base[1] = rand256();
    run_cmd(1, 1'b0, 4'h1, 12'h123, '0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
